// File: rtl/ploader.sv
// rtl/ploader.sv - UART 8N1 program loader: assembles little-endian words and strobes them out with a byte address.
module ploader #(
  parameter int SERIAL_WCNT = 100,
  parameter int LOAD_SIZE   = 8192
) (
  input  logic        CLK,
  input  logic        RST_X,
  input  logic        RXD,
  output logic [31:0] ADDR,
  output logic [31:0] DATA,
  output logic        WE,
  output logic        DONE
);

  localparam int CW = $clog2(SERIAL_WCNT);
  localparam int BW = $clog2(LOAD_SIZE) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SERIAL_WCNT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(SERIAL_WCNT - 1);
  localparam logic [BW-1:0] LOAD_BYTES = BW'(LOAD_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic [BW-1:0] byte_cnt_q;
  logic [23:0]   buf_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          we_q;
  logic          done_q;

  assign ADDR = addr_q;
  assign DATA = data_q;
  assign WE   = we_q;
  assign DONE = done_q;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_cnt_q <= '0;
      buf_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      // Address advances and completion is judged in the cycle after the strobe.
      if (we_q) begin
        addr_q <= addr_q + 32'd4;
        if (byte_cnt_q == LOAD_BYTES) begin
          done_q <= 1'b1;
        end
      end

      if (done_q) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!RXD) begin
              state_q <= S_START;
              cnt_q   <= '0;
            end
          end
          S_START: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q     <= '0;
              bit_cnt_q <= '0;
              state_q   <= RXD ? S_IDLE : S_DATA;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_DATA: begin
            if (cnt_q == FULL_LAST) begin
              cnt_q     <= '0;
              shift_q   <= {RXD, shift_q[7:1]};
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= S_STOP;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_STOP: begin
            if (cnt_q == FULL_LAST) begin
              cnt_q <= '0;
              if (RXD) begin
                state_q    <= S_IDLE;
                byte_cnt_q <= byte_cnt_q + 1'b1;
                case (byte_cnt_q[1:0])
                  2'd0: buf_q[7:0]   <= shift_q;
                  2'd1: buf_q[15:8]  <= shift_q;
                  2'd2: buf_q[23:16] <= shift_q;
                  default: begin
                    data_q <= {shift_q, buf_q};
                    we_q   <= 1'b1;
                  end
                endcase
              end else begin
                state_q <= S_WAIT;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_WAIT: begin
            if (RXD) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ploader.sv
// tb/tb_ploader.sv - directed bench for ploader with a word-level reference model and per-cycle output compare.
module tb_ploader;

  localparam int W  = 8;
  localparam int LS = 8;

  logic        CLK;
  logic        RST_X;
  logic        RXD;
  logic [31:0] ADDR;
  logic [31:0] DATA;
  logic        WE;
  logic        DONE;

  ploader #(.SERIAL_WCNT(W), .LOAD_SIZE(LS)) dut (
    .CLK  (CLK),
    .RST_X(RST_X),
    .RXD  (RXD),
    .ADDR (ADDR),
    .DATA (DATA),
    .WE   (WE),
    .DONE (DONE)
  );

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  model_bytes[$];
  int          model_words;
  bit          model_done;
  int          done_cyc;

  int          cyc;
  int          n_checks;
  int          n_fail;
  int          we_count;
  logic [31:0] last_addr;
  logic [31:0] last_data;
  logic [31:0] held_addr;
  logic [31:0] held_data;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word-level model: bytes are gathered in arrival order and a write is due
  // one cycle after the stop-bit centre of every fourth accepted byte.
  task automatic model_accept(input logic [7:0] b, input int stop_cyc);
    wr_t w;
    model_bytes.push_back(b);
    if (model_bytes.size() == 4) begin
      w.cyc  = stop_cyc;
      w.addr = 32'(model_words * 4);
      w.data = {model_bytes[3], model_bytes[2], model_bytes[1], model_bytes[0]};
      exp_q.push_back(w);
      model_words++;
      model_bytes.delete();
      if (model_words * 4 == LS) begin
        model_done = 1'b1;
        done_cyc   = stop_cyc + 1;
      end
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    int k;
    k = cyc + 1;
    if (stop_bit && !model_done) model_accept(b, k + W / 2 + 9 * W);
    RXD = 1'b0;
    hold(W);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      hold(W);
    end
    RXD = stop_bit;
    hold(W);
  endtask

  task automatic idle(input int n);
    RXD = 1'b1;
    hold(n);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    logic [31:0] v;
    v = w;
    for (int i = 0; i < 4; i++) begin
      send_frame(v[8*i +: 8], 1'b1);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic do_reset(input int n);
    RST_X = 1'b0;
    RXD   = 1'b1;
    exp_q.delete();
    model_bytes.delete();
    model_words = 0;
    model_done  = 1'b0;
    done_cyc    = -1;
    hold(n);
    RST_X = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (!RST_X) begin
      check("rst_addr", ADDR, 32'h0);
      check("rst_data", DATA, 32'h0);
      check("rst_we", {31'h0, WE}, 32'h0);
      check("rst_done", {31'h0, DONE}, 32'h0);
      held_addr = 32'h0;
      held_data = 32'h0;
      we_count  = 0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL missed_we: got no strobe expected write at cycle %0d addr %h", exp_q[0].cyc, exp_q[0].addr);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        check("we_pulse", {31'h0, WE}, 32'h1);
        check("we_addr", ADDR, exp_q[0].addr);
        check("we_data", DATA, exp_q[0].data);
        held_addr = exp_q[0].addr + 32'd4;
        held_data = exp_q[0].data;
        last_addr = ADDR;
        last_data = DATA;
        we_count++;
        void'(exp_q.pop_front());
      end else begin
        check("we_idle", {31'h0, WE}, 32'h0);
        check("addr_hold", ADDR, (we_count > 0) ? held_addr - 32'd4 + 32'd4 : 32'h0);
        check("data_hold", DATA, held_data);
      end
      check("done", {31'h0, DONE}, {31'h0, (done_cyc >= 0 && cyc >= done_cyc)});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    we_count  = 0;
    last_addr = '0;
    last_data = '0;
    held_addr = '0;
    held_data = '0;
    RXD       = 1'b1;
    RST_X     = 1'b0;
    model_words = 0;
    model_done  = 1'b0;
    done_cyc    = -1;
    @(posedge CLK);
    #1;
    do_reset(3);
    idle(5);

    // First word with idle gaps, then a back-to-back second word completes the load.
    send_word(32'h12345678, 3);
    idle(4);
    check("w0_count", 32'(we_count), 32'd1);
    check("w0_data", last_data, 32'h12345678);
    check("w0_addr", last_addr, 32'h0);
    check("w0_done", {31'h0, DONE}, 32'h0);
    send_word(32'hDEADBEEF, 0);
    idle(4);
    check("w1_count", 32'(we_count), 32'd2);
    check("w1_data", last_data, 32'hDEADBEEF);
    check("w1_addr", last_addr, 32'h4);
    check("w1_done", {31'h0, DONE}, 32'h1);
    send_word(32'hCAFEF00D, 1);
    idle(4);
    check("post_done_count", 32'(we_count), 32'd2);
    check("post_done_addr", ADDR, 32'h8);

    // Short low glitch while idle must be rejected.
    do_reset(3);
    idle(3);
    RXD = 1'b0;
    hold(2);
    idle(20);
    check("glitch_count", 32'(we_count), 32'd0);
    send_word(32'hA1B2C3D4, 2);
    idle(4);
    check("glitch_count2", 32'(we_count), 32'd1);
    check("glitch_data", last_data, 32'hA1B2C3D4);
    check("glitch_addr", last_addr, 32'h0);

    // Framing error: bad stop bit byte is dropped.
    do_reset(3);
    idle(3);
    send_frame(8'h99, 1'b0);
    idle(3);
    send_word(32'h0BADF00D, 1);
    idle(4);
    check("frame_count", 32'(we_count), 32'd1);
    check("frame_data", last_data, 32'h0BADF00D);
    check("frame_addr", last_addr, 32'h0);

    // Reset mid-word discards the partial bytes.
    do_reset(3);
    idle(3);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2);
    do_reset(3);
    idle(3);
    send_word(32'h55AA33CC, 2);
    idle(4);
    check("rst_mid_count", 32'(we_count), 32'd1);
    check("rst_mid_data", last_data, 32'h55AA33CC);
    check("rst_mid_addr", last_addr, 32'h0);

    // Eight bytes fully back-to-back.
    do_reset(3);
    idle(3);
    send_word(32'h03020100, 0);
    send_word(32'h07060504, 0);
    idle(4);
    check("b2b_count", 32'(we_count), 32'd2);
    check("b2b_data", last_data, 32'h07060504);
    check("b2b_addr", last_addr, 32'h4);
    check("b2b_done", {31'h0, DONE}, 32'h1);

    idle(20);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
